// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing defaults, axis helpers, region/state enums and colour-bar constants
package video_timing_pkg;
  localparam int DEF_H_DISP = 800;
  localparam int DEF_H_FP = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP = 64;
  localparam int DEF_V_DISP = 600;
  localparam int DEF_V_FP = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP = 23;
  localparam int DEF_PREFETCH = 4;
  localparam int DEF_SYNC_POL = 1;
  typedef enum logic [1:0] {R_ACTIVE, R_FP, R_SYNC, R_BP} region_e;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] CYAN = 24'h00FFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] BLUE = 24'h0000FF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [7:0][23:0] BAR_RGB = {BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
  function automatic int axis_total(input int disp, input int fp, input int s, input int bp);
    return disp + fp + s + bp;
  endfunction
  function automatic int h_total(input int disp, input int fp, input int s, input int bp);
    return axis_total(disp, fp, s, bp);
  endfunction
  function automatic int v_total(input int disp, input int fp, input int s, input int bp);
    return axis_total(disp, fp, s, bp);
  endfunction
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction
endpackage

// File: rtl/video_timing_ctrl_axis.sv
// timing_axis: one wrapping timing counter (display, front porch, sync, back porch) with region decode
// Ports: clk, rst (sync, active-high), inc (advance one step); cnt (current count),
//   cnt_nxt / region_nxt (value and region after this edge), wrap (count leaves its last value now).
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int W = 11,
  parameter int DISP = 800,
  parameter int FP = 56,
  parameter int SYNC = 120,
  parameter int BP = 64,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output region_e      region_nxt,
  output logic         wrap
);
  localparam int TOTAL = axis_total(DISP, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] END_DISP = W'(DISP);
  localparam logic [W-1:0] END_FP = W'(DISP + FP);
  localparam logic [W-1:0] END_SYNC = W'(DISP + FP + SYNC);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    wrap = inc && cnt_q == LAST;
    cnt_d = !inc ? cnt_q : wrap ? '0 : cnt_q + W'(1);
    region_nxt = cnt_d < END_DISP ? R_ACTIVE : cnt_d < END_FP ? R_FP : cnt_d < END_SYNC ? R_SYNC : R_BP;
  end
  always_ff @(posedge clk) cnt_q <= rst ? W'(RST_VAL) : cnt_d;
  assign cnt = cnt_q;
  assign cnt_nxt = cnt_d;
endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: 800x600@72 video timing generator with pixel prefetch and frame-safe start/stop
// Ports: clk (50 MHz pixel clock), rst (sync, active-high), enable (run request);
//   running, hsync/vsync (SYNC_POL level), active, blank, x/y position, line_start, frame_start,
//   pixel_req (pixel PREFETCH cycles ahead is active), pattern_rgb (colour bars).
// Colour-bar test pattern is built only when VIDEO_TIMING_TEST_PATTERN_EN is defined; otherwise pattern_rgb is 0.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int PREFETCH = DEF_PREFETCH,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        blank,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        pixel_req,
  output logic [23:0] pattern_rgb
);
  localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_DISP);
  localparam logic [10:0] H_PF = 11'(PREFETCH);
  localparam logic [10:0] H_PF_WRAP = 11'(H_TOTAL - PREFETCH);
  localparam logic [10:0] H_PF_BACK = 11'(PREFETCH - H_TOTAL);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_COMMIT = 10'(V_TOTAL - 2);
  localparam logic [9:0] V_ACT = 10'(V_DISP);
  localparam logic SYNC_ON = SYNC_POL != 0;
  state_e state_q, state_d;
  logic run_d, h_wrap, v_wrap, pf_wrap;
  logic [10:0] h_q, h_d, hp;
  logic [9:0] v_q, v_d, vp;
  region_e h_reg, v_reg;
  logic running_q, hsync_q, vsync_q, active_q, blank_q, line_start_q, frame_start_q, pixel_req_q;
  logic hsync_d, vsync_d, active_d, line_start_d, frame_start_d, pixel_req_d;
  timing_axis #(.W(11), .DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .RST_VAL(0)) u_h (
    .clk(clk), .rst(rst), .inc(state_q == RUN), .cnt(h_q), .cnt_nxt(h_d), .region_nxt(h_reg), .wrap(h_wrap)
  );
  timing_axis #(.W(10), .DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .RST_VAL(V_TOTAL - 1)) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap), .cnt(v_q), .cnt_nxt(v_d), .region_nxt(v_reg), .wrap(v_wrap)
  );
  always_comb begin
    // Stopping is only considered at the end of the second-to-last line, so the counters land on
    // the idle position (0, V_TOTAL-1) and a restart begins on the last back-porch line.
    state_d = state_q == IDLE ? (enable ? RUN : IDLE)
            : (h_q == H_LAST && v_q == V_COMMIT && !enable) ? IDLE : RUN;
    run_d = state_d == RUN;
    // Look PREFETCH pixels ahead of the next position, wrapping into the next line/frame.
    pf_wrap = h_d >= H_PF_WRAP;
    hp = h_d + (pf_wrap ? H_PF_BACK : H_PF);
    vp = !pf_wrap ? v_d : v_d == V_LAST ? '0 : v_d + 10'd1;
    active_d = run_d && h_d < H_ACT && v_d < V_ACT;
    hsync_d = (run_d && h_reg == R_SYNC) == SYNC_ON;
    vsync_d = (run_d && v_reg == R_SYNC) == SYNC_ON;
    line_start_d = run_d && h_d == '0;
    frame_start_d = v_wrap;
    pixel_req_d = run_d && hp < H_ACT && vp < V_ACT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      running_q <= 1'b0;
      hsync_q <= !SYNC_ON;
      vsync_q <= !SYNC_ON;
      active_q <= 1'b0;
      blank_q <= 1'b1;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      running_q <= run_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      active_q <= active_d;
      blank_q <= !active_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_req_q <= pixel_req_d;
    end
  end
  assign running = running_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign active = active_q;
  assign blank = blank_q;
  assign x = h_q;
  assign y = v_q;
  assign line_start = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_req = pixel_req_q;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam logic [10:0] H_BAR = 11'(H_DISP / 8);
  logic [23:0] pattern_q, pattern_d;
  always_comb pattern_d = active_d ? bar_rgb(3'(h_d / H_BAR)) : '0;
  always_ff @(posedge clk) pattern_q <= rst ? '0 : pattern_d;
  assign pattern_rgb = pattern_q;
`else
  assign pattern_rgb = '0;
`endif
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: randomized and directed checks of video_timing_ctrl against a position-based model
module tb_video_timing_ctrl;
  localparam int HD = 16, HF = 3, HS = 4, HB = 5;
  localparam int VD = 8, VF = 2, VS = 2, VB = 3;
  localparam int PF = 4, SP = 0;
  localparam int HT = HD + HF + HS + HB, VT = VD + VF + VS + VB, FRAME = HT * VT;
  localparam int RST_POS = (VT - 1) * HT, COMMIT = FRAME - HT - 1;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic running, hsync, vsync, active, blank, line_start, frame_start, pixel_req;
  logic [10:0] x;
  logic [9:0] y;
  logic [23:0] rgb;
  logic d_running, d_hsync, d_vsync, d_active, d_blank, d_line_start, d_frame_start, d_pixel_req;
  logic [10:0] d_x;
  logic [9:0] d_y;
  logic [23:0] d_rgb;
  int passed = 0, total = 0, t = 0, m_pos = RST_POS, n_act = 0, n_req = 0;
  bit m_run = 1'b0, win = 1'b0;
  always #10 clk = ~clk;
  video_timing_ctrl #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PREFETCH(PF), .SYNC_POL(SP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .running(running), .hsync(hsync), .vsync(vsync),
    .active(active), .blank(blank), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start), .pixel_req(pixel_req), .pattern_rgb(rgb)
  );
  video_timing_ctrl dut_d (
    .clk(clk), .rst(rst), .enable(enable), .running(d_running), .hsync(d_hsync), .vsync(d_vsync),
    .active(d_active), .blank(d_blank), .x(d_x), .y(d_y), .line_start(d_line_start),
    .frame_start(d_frame_start), .pixel_req(d_pixel_req), .pattern_rgb(d_rgb)
  );
  function automatic bit is_act(int p);
    return (p % HT) < HD && (p / HT) < VD;
  endfunction
  function automatic logic [23:0] exp_rgb(bit a, int h);
    int i = h / (HD / 8);
    return (a && PAT) ? {{8{i % 4 < 2}}, {8{i < 4}}, {8{i % 2 == 0}}} : 24'h0;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, t);
  endtask
  task automatic step();
    int h, v, np;
    bit a, hs, vs;
    @(posedge clk);
    #1;
    t++;
    if (rst) begin
      m_run = 1'b0;
      m_pos = RST_POS;
    end else if (!m_run) m_run = enable;
    else begin
      if (m_pos == COMMIT && !enable) m_run = 1'b0;
      m_pos = (m_pos + 1) % FRAME;
    end
    h = m_pos % HT;
    v = m_pos / HT;
    np = (m_pos + PF) % FRAME;
    a = m_run && is_act(m_pos);
    hs = (m_run && h >= HD + HF && h < HD + HF + HS) ^ (SP == 0);
    vs = (m_run && v >= VD + VF && v < VD + VF + VS) ^ (SP == 0);
    chk("ctrl", 32'({running, hsync, vsync, active, blank, line_start, frame_start, pixel_req}),
        32'({m_run, hs, vs, a, !a, m_run && h == 0, m_run && m_pos == 0, m_run && is_act(np)}));
    chk("x", 32'(x), h);
    chk("y", 32'(y), v);
    chk("rgb", 32'(rgb), 32'(exp_rgb(a, h)));
    if (!running) win = 1'b0;
    else if (frame_start) begin
      if (win) begin
        chk("active/frame", n_act, HD * VD);
        chk("req/frame", n_req, HD * VD);
      end
      n_act = 0;
      n_req = 0;
      win = 1'b1;
    end
    if (win) begin
      n_act += int'(active);
      n_req += int'(pixel_req);
    end
  endtask
  task automatic wait_pos(int p);
    int n = 0;
    while (!(m_run && m_pos == p) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("wait_pos x", 32'(x), p % HT);
    chk("wait_pos y", 32'(y), p / HT);
  endtask
  initial begin
    int n;
    logic [10:0] last_x;
    logic [9:0] last_y;
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    chk("d rst running", 32'(d_running), 0);
    chk("d rst blank", 32'(d_blank), 1);
    chk("d rst hsync", 32'(d_hsync), 0);
    chk("d rst x", 32'(d_x), 0);
    chk("d rst y", 32'(d_y), 665);
    chk("d rst req", 32'(d_pixel_req), 0);
    rst = 1'b0;
    t = 0;
    repeat (1900) begin
      step();
      if (t == 1) begin
        chk("d start running", 32'(d_running), 1);
        chk("d start x", 32'(d_x), 0);
        chk("d start y", 32'(d_y), 665);
        chk("d start line", 32'(d_line_start), 1);
        chk("d start vsync", 32'(d_vsync), 0);
      end
      if (t == 856) chk("d hsync 855", 32'(d_hsync), 0);
      if (t == 857) chk("d hsync 856", 32'(d_hsync), 1);
      if (t == 976) chk("d hsync 975", 32'(d_hsync), 1);
      if (t == 977) chk("d hsync 976", 32'(d_hsync), 0);
      if (t == 1036) chk("d req 1035", 32'(d_pixel_req), 0);
      if (t == 1037) chk("d req 1036", 32'(d_pixel_req), 1);
      if (t == 1040) chk("d fs early", 32'(d_frame_start), 0);
      if (t == 1041) begin
        chk("d fs", 32'(d_frame_start), 1);
        chk("d fs x", 32'(d_x), 0);
        chk("d fs y", 32'(d_y), 0);
        chk("d fs active", 32'(d_active), 1);
        chk("d rgb x0", 32'(d_rgb), PAT ? 32'hFFFFFF : 0);
      end
      if (t == 1191) chk("d rgb x150", 32'(d_rgb), PAT ? 32'hFFFF00 : 0);
      if (t == 1840) chk("d rgb x799", 32'(d_rgb), 0);
      if (t == 1841) chk("d rgb blank", 32'(d_rgb), 0);
    end
    wait_pos(4 * HT + 2);
    enable = 1'b0;
    wait_pos(6 * HT + 7);
    enable = 1'b1;
    repeat (FRAME) step();
    chk("no stop", 32'(running), 1);
    wait_pos(9 * HT + 3);
    enable = 1'b0;
    n = 0;
    last_x = x;
    last_y = y;
    while (running && n < 2 * FRAME) begin
      last_x = x;
      last_y = y;
      step();
      n++;
    end
    chk("stop running", 32'(running), 0);
    chk("stop commit x", 32'(last_x), HT - 1);
    chk("stop commit y", 32'(last_y), VT - 2);
    chk("stop idle x", 32'(x), 0);
    chk("stop idle y", 32'(y), VT - 1);
    repeat (60) step();
    enable = 1'b1;
    wait_pos(5 * HT + 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst running", 32'(running), 0);
    chk("midrst blank", 32'(blank), 1);
    chk("midrst hsync", 32'(hsync), 1);
    chk("midrst vsync", 32'(vsync), 1);
    chk("midrst x", 32'(x), 0);
    chk("midrst y", 32'(y), VT - 1);
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      rst = $urandom_range(0, 799) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
